// File: rtl/oh_util_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oh_util_pkg
// Description : One-hot helpers shared by one-hot pointer consumers:
//               rotate-left of a one-hot pointer and AND-OR one-hot select.
//               Vectors are carried at OH_MAX_SIZE bits; callers size-cast
//               their narrower pointers in and out.
// Revision    : 1.0 - initial release
// ============================================================================
package oh_util_pkg;

    // Largest pointer/slot count the helpers support.
    localparam int OH_MAX_SIZE = 64;

    // Rotate a one-hot pointer left within its low 'size' bits:
    // {ptr[size-2:0], ptr[size-1]}. Bits at or above 'size' return zero.
    function automatic logic [OH_MAX_SIZE-1:0] oh_rotl(
        input logic [OH_MAX_SIZE-1:0] ptr,
        input int                     size
    );
        logic [OH_MAX_SIZE-1:0] v_rot;
        v_rot = '0;
        for (int i = 0; i < OH_MAX_SIZE - 1; i++) begin
            if (i + 1 < size) begin
                v_rot[i+1] = ptr[i];
            end
        end
        for (int i = 0; i < OH_MAX_SIZE; i++) begin
            if (i + 1 == size) begin
                v_rot[0] = ptr[i];
            end
        end
        return v_rot;
    endfunction

    // AND-OR select of one bit column: data[i] is the bit contributed by
    // slot i, sel is the one-hot slot select.
    function automatic logic oh_mux(
        input logic [OH_MAX_SIZE-1:0] sel,
        input logic [OH_MAX_SIZE-1:0] data
    );
        return |(sel & data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oh_ptr_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : oh_ptr_fifo_if
// Description : Handshake and status bundle of the one-hot pointer FIFO.
//               master = producer/consumer side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface oh_ptr_fifo_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               push_valid;
    logic               push_ready;
    logic [WIDTH-1:0]   push_data;
    logic               pop_valid;
    logic               pop_ready;
    logic [WIDTH-1:0]   pop_data;
    logic [DEPTH-1:0]   wr_ptr;
    logic [DEPTH-1:0]   rd_ptr;
    logic [C_CNT_W-1:0] count;
    logic               full;
    logic               empty;

    modport master (
        output flush, push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, wr_ptr, rd_ptr, count, full, empty
    );

    modport slave (
        input  flush, push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, wr_ptr, rd_ptr, count, full, empty
    );

endinterface
`default_nettype wire

// File: rtl/oh_rotate_ptr.sv
`default_nettype none
// ============================================================================
// Module      : oh_rotate_ptr
// Description : Registered one-hot pointer. Resets or clears to bit 0 and
//               rotates left by one slot whenever i_adv is high.
// Revision    : 1.0 - initial release
// ============================================================================
module oh_rotate_ptr
    import oh_util_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  wire logic            i_clk,
    input  wire logic            i_reset,
    input  wire logic            i_clear,
    input  wire logic            i_adv,
    output logic [SIZE-1:0]      o_ptr
);

    localparam logic [SIZE-1:0] C_PTR_INIT = SIZE'(1);

    logic [SIZE-1:0] r_ptr;

    // Pointer register: reset/clear win over advance.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_ptr <= C_PTR_INIT;
        end else if (i_adv) begin
            r_ptr <= SIZE'(oh_rotl(OH_MAX_SIZE'(r_ptr), SIZE));
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/oh_ptr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : oh_ptr_fifo
// Description : In-order circular buffer addressed by rotating one-hot
//               write/read pointers, with occupancy count and valid/ready
//               handshakes. Head data is an AND-OR select of the array by
//               the read pointer, so there is no fall-through from push.
// Revision    : 1.0 - initial release
// ============================================================================
module oh_ptr_fifo
    import oh_util_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    oh_ptr_fifo_if.slave    bus
);

    localparam int                 C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]   w_wr_ptr;
    logic [DEPTH-1:0]   w_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_push_fire;
    logic               w_pop_fire;
    logic               w_discard;
    logic [WIDTH-1:0]   w_pop_data;

    // Status comes only from the count register, so ready/valid never
    // depend combinationally on the other side's handshake inputs.
    assign w_full      = (r_count == C_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push_fire = bus.push_valid && !w_full;
    assign w_pop_fire  = bus.pop_ready && !w_empty;
    // A handshake in a reset or flush cycle is dropped entirely.
    assign w_discard   = i_reset || bus.flush;

    oh_rotate_ptr #(.SIZE(DEPTH)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (bus.flush),
        .i_adv   (w_push_fire),
        .o_ptr   (w_wr_ptr)
    );

    oh_rotate_ptr #(.SIZE(DEPTH)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (bus.flush),
        .i_adv   (w_pop_fire),
        .o_ptr   (w_rd_ptr)
    );

    // Occupancy: +1 on push only, -1 on pop only, else hold.
    always_ff @(posedge i_clk) begin
        if (w_discard) begin
            r_count <= '0;
        end else begin
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage: each slot loads when a kept push targets it; no reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge i_clk) begin
            if (w_push_fire && !w_discard && w_wr_ptr[g]) begin
                r_mem[g] <= bus.push_data;
            end
        end
    end

    // Head data: per-bit AND-OR of every slot masked by the read pointer.
    always_comb begin
        logic [OH_MAX_SIZE-1:0] v_col;
        w_pop_data = '0;
        for (int b = 0; b < WIDTH; b++) begin
            v_col = '0;
            for (int s = 0; s < DEPTH; s++) begin
                v_col[s] = r_mem[s][b];
            end
            w_pop_data[b] = oh_mux(OH_MAX_SIZE'(w_rd_ptr), v_col);
        end
    end

    assign bus.push_ready = !w_full;
    assign bus.pop_valid  = !w_empty;
    assign bus.pop_data   = w_pop_data;
    assign bus.wr_ptr     = w_wr_ptr;
    assign bus.rd_ptr     = w_rd_ptr;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_oh_ptr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_oh_ptr_fifo
// Description : Self-checking bench for oh_ptr_fifo (DEPTH=4, WIDTH=32):
//               constant-vector table, directed corner sequences and a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oh_ptr_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;

    oh_ptr_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    oh_ptr_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored entries plus integer slot indices.
    logic [WIDTH-1:0] mq[$];
    int               m_wr = 0;
    int               m_rd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        bit m_full;
        bit m_empty;
        bit pf;
        bit qf;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        pf = bus.push_valid && !m_full;
        qf = bus.pop_ready && !m_empty;
        if (rst || bus.flush) begin
            mq.delete();
            m_wr = 0;
            m_rd = 0;
        end else begin
            if (qf) begin
                void'(mq.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (pf) begin
                mq.push_back(bus.push_data);
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    endtask

    task automatic check_model();
        chk("count",      64'(bus.count),      64'(mq.size()));
        chk("full",       64'(bus.full),       64'(mq.size() == DEPTH));
        chk("empty",      64'(bus.empty),      64'(mq.size() == 0));
        chk("push_ready", 64'(bus.push_ready), 64'(mq.size() != DEPTH));
        chk("pop_valid",  64'(bus.pop_valid),  64'(mq.size() != 0));
        chk("wr_ptr",     64'(bus.wr_ptr),     64'(1) << m_wr);
        chk("rd_ptr",     64'(bus.rd_ptr),     64'(1) << m_rd);
        chk("wr_onehot",  64'($onehot(bus.wr_ptr)), 64'(1));
        chk("rd_onehot",  64'($onehot(bus.rd_ptr)), 64'(1));
        if (mq.size() != 0) begin
            chk("pop_data", 64'(bus.pop_data), 64'(mq[0]));
        end
    endtask

    // One clock: status must not react to freshly applied handshake
    // inputs, then the model and DUT both take the edge.
    task automatic step();
        chk("pre_push_ready", 64'(bus.push_ready), 64'(mq.size() != DEPTH));
        chk("pre_pop_valid",  64'(bus.pop_valid),  64'(mq.size() != 0));
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic fl, input logic pv, input logic [WIDTH-1:0] pd, input logic pr);
        bus.flush      = fl;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
    endtask

    typedef struct {
        logic             pv;
        logic [WIDTH-1:0] pd;
        logic             pr;
        logic [2:0]       cnt;
        logic [3:0]       wr;
        logic [3:0]       rd;
        logic             vld;
        logic [WIDTH-1:0] head;
    } vec_t;

    vec_t vecs[11];

    int wraps_wr;
    int wraps_rd;

    initial begin
        // Fill, push while full, drain in order, pop while empty, refill.
        vecs[0]  = '{1'b1, 32'hA0, 1'b0, 3'd1, 4'b0010, 4'b0001, 1'b1, 32'hA0};
        vecs[1]  = '{1'b1, 32'hA1, 1'b0, 3'd2, 4'b0100, 4'b0001, 1'b1, 32'hA0};
        vecs[2]  = '{1'b1, 32'hA2, 1'b0, 3'd3, 4'b1000, 4'b0001, 1'b1, 32'hA0};
        vecs[3]  = '{1'b1, 32'hA3, 1'b0, 3'd4, 4'b0001, 4'b0001, 1'b1, 32'hA0};
        vecs[4]  = '{1'b1, 32'hBB, 1'b0, 3'd4, 4'b0001, 4'b0001, 1'b1, 32'hA0};
        vecs[5]  = '{1'b0, 32'h00, 1'b1, 3'd3, 4'b0001, 4'b0010, 1'b1, 32'hA1};
        vecs[6]  = '{1'b0, 32'h00, 1'b1, 3'd2, 4'b0001, 4'b0100, 1'b1, 32'hA2};
        vecs[7]  = '{1'b0, 32'h00, 1'b1, 3'd1, 4'b0001, 4'b1000, 1'b1, 32'hA3};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 3'd0, 4'b0001, 4'b0001, 1'b0, 32'h00};
        vecs[9]  = '{1'b0, 32'h00, 1'b1, 3'd0, 4'b0001, 4'b0001, 1'b0, 32'h00};
        vecs[10] = '{1'b1, 32'h77, 1'b0, 3'd1, 4'b0010, 4'b0001, 1'b1, 32'h77};

        // Reset
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("rst_wr_ptr",     64'(bus.wr_ptr),     64'h1);
        chk("rst_rd_ptr",     64'(bus.rd_ptr),     64'h1);
        chk("rst_count",      64'(bus.count),      64'h0);
        chk("rst_empty",      64'(bus.empty),      64'h1);
        chk("rst_full",       64'(bus.full),       64'h0);
        chk("rst_push_ready", 64'(bus.push_ready), 64'h1);
        chk("rst_pop_valid",  64'(bus.pop_valid),  64'h0);

        // Constant-vector table
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, vecs[i].pv, vecs[i].pd, vecs[i].pr);
            step();
            chk($sformatf("vec%0d_count", i), 64'(bus.count),  64'(vecs[i].cnt));
            chk($sformatf("vec%0d_wr", i),    64'(bus.wr_ptr), 64'(vecs[i].wr));
            chk($sformatf("vec%0d_rd", i),    64'(bus.rd_ptr), 64'(vecs[i].rd));
            chk($sformatf("vec%0d_vld", i),   64'(bus.pop_valid), 64'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_head", i), 64'(bus.pop_data), 64'(vecs[i].head));
            end
        end

        // Steady state at count 2: simultaneous push/pop for 20 cycles
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        step();
        chk("steady_start_count", 64'(bus.count), 64'd2);
        wraps_wr = 0;
        wraps_rd = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);
            step();
            chk("steady_count", 64'(bus.count), 64'd2);
            if (bus.wr_ptr == 4'b0001) wraps_wr++;
            if (bus.rd_ptr == 4'b0001) wraps_rd++;
        end
        chk("steady_wr_wraps", 64'(wraps_wr), 64'd5);
        chk("steady_rd_wraps", 64'(wraps_rd), 64'd5);

        // Fill to full, then flush with both handshakes requested
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
            step();
        end
        chk("pre_flush_full", 64'(bus.full), 64'h1);
        drive(1'b1, 1'b1, 32'hDD, 1'b1);
        step();
        chk("flush_count",      64'(bus.count),      64'h0);
        chk("flush_wr_ptr",     64'(bus.wr_ptr),     64'h1);
        chk("flush_rd_ptr",     64'(bus.rd_ptr),     64'h1);
        chk("flush_pop_valid",  64'(bus.pop_valid),  64'h0);
        chk("flush_push_ready", 64'(bus.push_ready), 64'h1);

        // No fall-through: 0x55 is not visible until after its edge
        drive(1'b0, 1'b1, 32'h55, 1'b1);
        #1;
        chk("nofall_pop_valid", 64'(bus.pop_valid), 64'h0);
        step();
        chk("push55_pop_valid", 64'(bus.pop_valid), 64'h1);
        chk("push55_pop_data",  64'(bus.pop_data),  64'h55);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 31) == 0), 1'($urandom), $urandom, 1'($urandom));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oh_ptr_fifo.md
# oh_ptr_fifo

Circular buffer that consumes one-hot write/read pointers: stores entries at the slot selected by a rotating one-hot write pointer and returns them from the slot selected by a rotating one-hot read pointer. It wraps the pointers with storage, occupancy tracking and valid/ready handshakes on both sides. It is used wherever a pipeline stage needs a small in-order queue whose slot index is consumed in one-hot form, for example by issue, commit or entry-select logic.

## Interface
- DEPTH, 4, number of entries; must be ≥ 2.
- WIDTH, 32, payload bits per entry.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous discard of all entries; keeps array contents.
- i_push_valid  in  1  producer presents an entry.
- o_push_ready  out  1  buffer can accept; equals !o_full.
- i_push_data  in  WIDTH  entry payload.
- o_pop_valid  out  1  head entry available; equals !o_empty.
- i_pop_ready  in  1  consumer takes the head entry.
- o_pop_data  out  WIDTH  head entry payload.
- o_wr_ptr  out  DEPTH  one-hot slot the next push writes.
- o_rd_ptr  out  DEPTH  one-hot slot currently at the head.
- o_count  out  $clog2(DEPTH+1)  number of valid entries.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.

## Operation
- Push fires when i_push_valid && o_push_ready. Pop fires when o_pop_valid && i_pop_ready.
- On a push, payload is written to the slot where o_wr_ptr is 1. The write pointer then rotates left: {ptr[DEPTH-2:0], ptr[DEPTH-1]}.
- On a pop, the read pointer rotates left in the same way.
- o_pop_data is the AND-OR of all entries masked by o_rd_ptr. It is combinational from registered state only; there is no path from i_push_data.
- Count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged.
  - neither: count unchanged.
- Full case: o_push_ready is 0, so only a pop can fire. After that pop, the buffer accepts a push on the next cycle.
- Empty case: o_pop_valid is 0, so a push and a pop never fire together. There is no fall-through.
- Wrap-around: after DEPTH pushes, bit 0 of the write pointer is set again. The read pointer behaves the same way.
- Pointer invariant: each pointer is exactly one-hot at all times.
- Reset and flush, each applied on the edge where it is sampled:
  - wr_ptr and rd_ptr are set to bit 0.
  - count is set to 0.
  - any push or pop fired in that cycle is discarded.
  - Reset takes priority over flush.
- The data array is not reset. A flush asserted while the buffer is full leaves it empty and ready on the next cycle.

## Timing
- Reset values: o_wr_ptr = 1, o_rd_ptr = 1, o_count = 0, o_empty = 1, o_full = 0, o_push_ready = 1, o_pop_valid = 0. o_pop_data is undefined until the first push.
- Push-to-pop latency is 1 cycle: an entry pushed at edge N is valid at o_pop_data after edge N. It can pop at edge N+1.
- Throughput: one push and one pop per cycle, sustained at any occupancy between 1 and DEPTH−1.
- o_push_ready and o_pop_valid are registered-state functions only. Neither depends combinationally on i_push_valid or i_pop_ready.
- i_flush and i_reset act on the same edge they are sampled. The first handshake after them is accepted on the following edge.

## Structure
- Shared package oh_util_pkg:
  - function oh_rotl(ptr), one-hot rotate left.
  - function oh_mux(sel, data[]), AND-OR select.
  - Both are reused by other one-hot consumers.
- Sub-module oh_rotate_ptr (parameter SIZE), instantiated twice (write and read):
  - ports i_clk, i_reset, i_clear, i_adv, o_ptr.
  - resets or clears to bit 0; rotates left when i_adv.
- The count register, storage array and handshake logic stay in oh_ptr_fifo.

## Test plan
- Reset, then 4 pushes of 0xA0..0xA3 with DEPTH=4, no pops → o_full=1, o_push_ready=0, o_wr_ptr=0001 (wrapped), o_count=4.
- From full, 4 pops → data 0xA0, 0xA1, 0xA2, 0xA3 in order. Then o_empty=1 and o_rd_ptr=0001.
- Hold count=2 and push and pop every cycle for 20 cycles → count stays 2, data stays in order, and both pointers wrap 5 times.
- Push while full, and pop_ready while empty → no state change and no pointer movement. An assertion checks the pointers stay one-hot.
- Full buffer, assert i_flush with i_push_valid=1 and i_pop_ready=1 → next cycle o_count=0, both pointers = 0001, o_pop_valid=0.
- Push 0x55 at edge N → o_pop_valid=1 and o_pop_data=0x55 after edge N. The entry is not visible in the same cycle as the push.
